// File: rtl/axis_frame_checker.sv
// rtl/axis_frame_checker.sv - passive AXI-Stream video frame/line checker with sticky errors and statistics
// Optional build macro AXIS_FRAME_CHECKSUM_EN adds frame_checksum (XOR of tdata over the last completed frame).
module axis_frame_checker #(
  parameter int T_DATA_WIDTH    = 64,
  parameter int T_USER_WIDTH    = 4,
  parameter int BEAT_CNT_WIDTH  = 16,
  parameter int LINE_CNT_WIDTH  = 12,
  parameter int FRAME_CNT_WIDTH = 32
) (
  input  logic                       aclk,
  input  logic                       aclk_reset,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tready,
  input  logic [T_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                       s_axis_tlast,
  input  logic [T_USER_WIDTH-1:0]    s_axis_tuser,
  input  logic [BEAT_CNT_WIDTH-1:0]  cfg_beats_per_line,
  input  logic [LINE_CNT_WIDTH-1:0]  cfg_lines_per_frame,
  input  logic                       err_clr,
  output logic                       frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic [LINE_CNT_WIDTH-1:0]  line_count,
  output logic [FRAME_CNT_WIDTH-1:0] stall_count,
  output logic [4:0]                 err_flags,
  output logic                       in_frame
`ifdef AXIS_FRAME_CHECKSUM_EN
  ,
  output logic [T_DATA_WIDTH-1:0]    frame_checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LINE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [BEAT_CNT_WIDTH-1:0]  BEAT_MAX  = '1;
  localparam logic [LINE_CNT_WIDTH-1:0]  LINE_MAX  = '1;
  localparam logic [FRAME_CNT_WIDTH-1:0] STALL_MAX = '1;

  state_t                     state_q;
  state_t                     state_d;
  logic [BEAT_CNT_WIDTH-1:0]  beat_cnt_q;
  logic [BEAT_CNT_WIDTH-1:0]  beat_cnt_d;
  logic                       beat_ovf_q;
  logic                       beat_ovf_d;
  logic [LINE_CNT_WIDTH-1:0]  line_cnt_d;
  logic [4:0]                 err_set;

  // Per-beat marker decode; only handshaked beats are meaningful.
  logic beat;
  logic sof;
  logic eof;
  logic sol;
  logic eol;
  logic active;
  logic line_start;
  logic line_end;
  logic frame_end;

  assign beat       = s_axis_tvalid & s_axis_tready;
  assign sof        = s_axis_tuser[0];
  assign eof        = s_axis_tuser[1];
  assign sol        = s_axis_tuser[2];
  assign eol        = s_axis_tuser[3];
  // A beat takes part in a frame if it opens one or arrives while a frame is open.
  assign active     = beat & (sof | (state_q != S_IDLE));
  // SOF always restarts; in GAP any beat opens the next line.
  assign line_start = sof | (state_q == S_GAP);
  // EOF without tlast is still treated as the end of the line and frame.
  assign line_end   = active & (s_axis_tlast | eof);
  assign frame_end  = active & eof;

  logic unused_user;
  assign unused_user = ^s_axis_tuser;

  // State register.
  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: only frame beats move the FSM; stray beats in IDLE are ignored.
  always_comb begin
    state_d = state_q;
    if (active) begin
      if (frame_end) begin
        state_d = S_IDLE;
      end else if (line_end) begin
        state_d = S_GAP;
      end else begin
        state_d = S_LINE;
      end
    end
  end

  // Counter updates and error detection for the current beat.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    beat_ovf_d = beat_ovf_q;
    line_cnt_d = line_count;
    err_set    = '0;
    if (beat) begin
      if (s_axis_tlast != eol) begin
        err_set[4] = 1'b1;
      end
      if (!active) begin
        err_set[1] = 1'b1;
      end else begin
        if (sof && (state_q != S_IDLE)) begin
          err_set[0] = 1'b1;
        end
        if (eof && !s_axis_tlast) begin
          err_set[4] = 1'b1;
        end
        if ((state_q == S_GAP) && !sof && !sol) begin
          err_set[4] = 1'b1;
        end
        if (sof) begin
          line_cnt_d = '0;
        end
        if (line_start) begin
          beat_cnt_d = BEAT_CNT_WIDTH'(1);
          beat_ovf_d = 1'b0;
        end else if (beat_cnt_q == BEAT_MAX) begin
          beat_ovf_d = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + BEAT_CNT_WIDTH'(1);
        end
        if (line_end) begin
          // A saturated beat counter can no longer prove the length, so flag it.
          if (beat_ovf_d ||
              ((cfg_beats_per_line != '0) && (beat_cnt_d != cfg_beats_per_line))) begin
            err_set[2] = 1'b1;
          end
          if (line_cnt_d != LINE_MAX) begin
            line_cnt_d = line_cnt_d + LINE_CNT_WIDTH'(1);
          end
        end
        if (frame_end && (cfg_lines_per_frame != '0) &&
            (line_cnt_d != cfg_lines_per_frame)) begin
          err_set[3] = 1'b1;
        end
      end
    end
  end

  // Registered counters, statistics and sticky errors (a new error beats err_clr).
  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      beat_cnt_q  <= '0;
      beat_ovf_q  <= 1'b0;
      line_count  <= '0;
      err_flags   <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      stall_count <= '0;
      in_frame    <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      beat_ovf_q <= beat_ovf_d;
      line_count <= line_cnt_d;
      err_flags  <= (err_clr ? 5'b00000 : err_flags) | err_set;
      frame_done <= frame_end;
      in_frame   <= (state_d != S_IDLE);
      if (frame_end) begin
        frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
      end
      if (s_axis_tvalid && !s_axis_tready && (stall_count != STALL_MAX)) begin
        stall_count <= stall_count + FRAME_CNT_WIDTH'(1);
      end
    end
  end

`ifdef AXIS_FRAME_CHECKSUM_EN
  logic [T_DATA_WIDTH-1:0] acc_q;
  logic [T_DATA_WIDTH-1:0] acc_d;

  assign acc_d = (sof ? '0 : acc_q) ^ s_axis_tdata;

  // Running XOR of frame data; published together with frame_done.
  always_ff @(posedge aclk) begin
    if (aclk_reset) begin
      acc_q          <= '0;
      frame_checksum <= '0;
    end else if (active) begin
      acc_q <= acc_d;
      if (frame_end) begin
        frame_checksum <= acc_d;
      end
    end
  end
`else
  logic unused_data;
  assign unused_data = ^s_axis_tdata;
`endif

endmodule

// File: tb/tb_axis_frame_checker.sv
// tb/tb_axis_frame_checker.sv - scoreboard bench for axis_frame_checker
module tb_axis_frame_checker;

  logic tb_CLK = 1'b0;
  always #5 tb_CLK = ~tb_CLK;

  logic        aclk_reset;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic [3:0]  s_axis_tuser;
  logic [15:0] cfg_beats_per_line;
  logic [11:0] cfg_lines_per_frame;
  logic        err_clr;
  logic        frame_done;
  logic [31:0] frame_count;
  logic [11:0] line_count;
  logic [31:0] stall_count;
  logic [4:0]  err_flags;
  logic        in_frame;
`ifdef AXIS_FRAME_CHECKSUM_EN
  logic [63:0] frame_checksum;
`endif

  axis_frame_checker dut (
    .aclk                (tb_CLK),
    .aclk_reset          (aclk_reset),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tuser        (s_axis_tuser),
    .cfg_beats_per_line  (cfg_beats_per_line),
    .cfg_lines_per_frame (cfg_lines_per_frame),
    .err_clr             (err_clr),
    .frame_done          (frame_done),
    .frame_count         (frame_count),
    .line_count          (line_count),
    .stall_count         (stall_count),
    .err_flags           (err_flags),
    .in_frame            (in_frame)
`ifdef AXIS_FRAME_CHECKSUM_EN
    ,
    .frame_checksum      (frame_checksum)
`endif
  );

  typedef struct {
    int          cyc;
    logic [31:0] fc;
    logic [11:0] lc;
    logic [4:0]  err;
    logic [63:0] ck;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic [31:0] exp_fc;
  logic [11:0] exp_lc;
  logic [4:0]  exp_err;
  logic [63:0] exp_ck;

  always @(posedge tb_CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_exp(input logic [31:0] fc, input logic [11:0] lc,
                         input logic [4:0] err, input logic [63:0] ck);
    exp_fc  = fc;
    exp_lc  = lc;
    exp_err = err;
    exp_ck  = ck;
  endtask

  task automatic send_beat(input bit sof, input bit eof, input bit sol, input bit eol,
                           input bit last, input logic [63:0] data);
    exp_t e;
    s_axis_tvalid = 1'b1;
    s_axis_tready = 1'b1;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    s_axis_tuser  = {eol, sol, eof, sof};
    if (eof) begin
      e.cyc = cyc + 1;
      e.fc  = exp_fc;
      e.lc  = exp_lc;
      e.err = exp_err;
      e.ck  = exp_ck;
      sb.push_back(e);
    end
    @(posedge tb_CLK);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 4'h0;
    s_axis_tdata  = 64'h0;
  endtask

  task automatic stall(input int n);
    s_axis_tvalid = 1'b1;
    s_axis_tready = 1'b0;
    s_axis_tlast  = 1'b1;
    s_axis_tuser  = 4'hF;
    s_axis_tdata  = 64'hDEAD;
    repeat (n) @(posedge tb_CLK);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tready = 1'b1;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 4'h0;
  endtask

  task automatic send_line(input bit first, input bit final_line, input int n,
                           input logic [63:0] start, input int stall_at);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) stall(7);
      send_beat(first && (i == 0), final_line && (i == n - 1), i == 0, i == n - 1,
                i == n - 1, start << i);
    end
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge tb_CLK);
    #1;
    err_clr = 1'b0;
  endtask

  // Monitor: every frame_done pulse is matched against the oldest expected frame.
  always @(negedge tb_CLK) begin
    exp_t e;
    if (frame_done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame_done: got frame_done=1 at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("frame_done_cycle", 64'(cyc), 64'(e.cyc));
        check("frame_count", 64'(frame_count), 64'(e.fc));
        check("line_count", 64'(line_count), 64'(e.lc));
        check("err_flags", 64'(err_flags), 64'(e.err));
`ifdef AXIS_FRAME_CHECKSUM_EN
        check("frame_checksum", frame_checksum, e.ck);
`endif
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_frame_done"}, 64'(frame_done), 64'h0);
    check({tag, "_frame_count"}, 64'(frame_count), 64'h0);
    check({tag, "_line_count"}, 64'(line_count), 64'h0);
    check({tag, "_stall_count"}, 64'(stall_count), 64'h0);
    check({tag, "_err_flags"}, 64'(err_flags), 64'h0);
    check({tag, "_in_frame"}, 64'(in_frame), 64'h0);
  endtask

  initial begin
    aclk_reset          = 1'b1;
    s_axis_tvalid       = 1'b0;
    s_axis_tready       = 1'b1;
    s_axis_tdata        = 64'h0;
    s_axis_tlast        = 1'b0;
    s_axis_tuser        = 4'h0;
    cfg_beats_per_line  = 16'd4;
    cfg_lines_per_frame = 12'd3;
    err_clr             = 1'b0;
    set_exp(0, 0, 0, 0);
    repeat (2) @(posedge tb_CLK);
    #1;
    aclk_reset = 1'b0;
    @(negedge tb_CLK);
    check_zero_outputs("reset");

    // Two nominal 4x3 frames.
    set_exp(1, 3, 5'b00000, 0);
    send_line(1, 0, 4, 0, -1); send_line(0, 0, 4, 0, -1); send_line(0, 1, 4, 0, -1);
    set_exp(2, 3, 5'b00000, 0);
    send_line(1, 0, 4, 0, -1); send_line(0, 0, 4, 0, -1); send_line(0, 1, 4, 0, -1);
    @(negedge tb_CLK);
    check("nominal_frame_count", 64'(frame_count), 64'd2);
    check("nominal_line_count", 64'(line_count), 64'd3);
    check("nominal_err_flags", 64'(err_flags), 64'h0);

    // Short second line: sticky line-length error until cleared.
    set_exp(3, 3, 5'b00100, 0);
    send_line(1, 0, 4, 0, -1); send_line(0, 0, 3, 0, -1); send_line(0, 1, 4, 0, -1);
    repeat (3) @(posedge tb_CLK);
    @(negedge tb_CLK);
    check("short_err_sticky", 64'(err_flags), 64'b00100);
    err_clr = 1'b1;
    @(posedge tb_CLK);
    #1;
    err_clr = 1'b0;
    @(negedge tb_CLK);
    check("short_err_cleared", 64'(err_flags), 64'h0);

    // Backpressure mid-line for 7 cycles.
    set_exp(4, 3, 5'b00000, 0);
    send_line(1, 0, 4, 0, -1); send_line(0, 0, 4, 0, 2); send_line(0, 1, 4, 0, -1);
    @(negedge tb_CLK);
    check("stall_count", 64'(stall_count), 64'd7);

    // SOF in the middle of a frame abandons it; the restarted frame completes.
    set_exp(5, 3, 5'b00001, 0);
    send_line(1, 0, 4, 0, -1);
    send_beat(0, 0, 1, 0, 0, 0);
    send_beat(0, 0, 0, 0, 0, 0);
    send_line(1, 0, 4, 0, -1); send_line(0, 0, 4, 0, -1); send_line(0, 1, 4, 0, -1);
    @(negedge tb_CLK);
    check("abort_frame_count", 64'(frame_count), 64'd5);
    clear_err();

    // Data beat in IDLE without SOF.
    send_beat(0, 0, 0, 0, 0, 64'h33);
    @(negedge tb_CLK);
    check("missing_sof", 64'(err_flags), 64'b00010);
    clear_err();

    // Frame with only two lines: line-count error.
    set_exp(6, 2, 5'b01000, 0);
    send_line(1, 0, 4, 0, -1); send_line(0, 1, 4, 0, -1);
    clear_err();

    // Reset during line 2, then the tail of that frame and a full new frame.
    send_line(1, 0, 4, 0, -1);
    send_beat(0, 0, 1, 0, 0, 0);
    send_beat(0, 0, 0, 0, 0, 0);
    @(negedge tb_CLK);
    check("mid_frame_in_frame", 64'(in_frame), 64'h1);
    aclk_reset = 1'b1;
    @(posedge tb_CLK);
    #1;
    aclk_reset = 1'b0;
    @(negedge tb_CLK);
    check_zero_outputs("midreset");
    send_beat(0, 0, 0, 0, 0, 0);
    send_beat(0, 0, 0, 1, 1, 0);
    @(negedge tb_CLK);
    check("post_reset_missing_sof", 64'(err_flags), 64'b00010);
    clear_err();
    set_exp(1, 3, 5'b00000, 0);
    send_line(1, 0, 4, 0, -1); send_line(0, 0, 4, 0, -1); send_line(0, 1, 4, 0, -1);

    // err_clr in the same cycle as a new line-length error.
    set_exp(2, 3, 5'b00100, 0);
    send_beat(1, 0, 1, 0, 0, 0);
    send_beat(0, 0, 0, 0, 0, 0);
    err_clr = 1'b1;
    send_beat(0, 0, 0, 1, 1, 0);
    err_clr = 1'b0;
    @(negedge tb_CLK);
    check("clr_vs_new_err", 64'(err_flags), 64'b00100);
    send_line(0, 0, 4, 0, -1); send_line(0, 1, 4, 0, -1);
    clear_err();

    // Single-beat frame.
    cfg_beats_per_line  = 16'd1;
    cfg_lines_per_frame = 12'd1;
    set_exp(3, 1, 5'b00000, 64'h5A);
    send_beat(1, 1, 1, 1, 1, 64'h5A);

    // Checksum frame 1,2,4,8.
    cfg_beats_per_line = 16'd4;
    set_exp(4, 1, 5'b00000, 64'hF);
    send_line(1, 1, 4, 64'h1, -1);

    repeat (3) @(posedge tb_CLK);
    @(negedge tb_CLK);
    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    check("final_err_flags", 64'(err_flags), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_checker.md
Name: axis_frame_checker

Overview:
- Passive, synthesizable monitor for an AXI-Stream video port (XGS sensor-to-DMA path). It taps tvalid/tready/tdata/tlast/tuser and never drives the stream.
- Parametrised in data width, user width and counter widths; it decodes per-beat SOF/EOF/SOL/EOL user flags.
- Checks line length and line count against programmed geometry and reports sticky protocol errors.
- Reports frame, line and backpressure statistics to the control register bank and to the verification bench.

Parameters:
- T_DATA_WIDTH, 64, tdata width in bits (8..512, multiple of 8)
- T_USER_WIDTH, 4, tuser width (>=4). Bit 0=SOF, 1=EOF, 2=SOL, 3=EOL; higher bits ignored.
- BEAT_CNT_WIDTH, 16, width of the beats-per-line counter
- LINE_CNT_WIDTH, 12, width of the lines-per-frame counter
- FRAME_CNT_WIDTH, 32, width of the frame and stall counters

Ports:
- aclk  in  1  clock
- aclk_reset  in  1  synchronous reset, active-high
- s_axis_tvalid  in  1  tapped stream valid
- s_axis_tready  in  1  tapped stream ready (observed, not driven)
- s_axis_tdata  in  T_DATA_WIDTH  tapped data
- s_axis_tlast  in  1  end of line
- s_axis_tuser  in  T_USER_WIDTH  frame/line markers
- cfg_beats_per_line  in  BEAT_CNT_WIDTH  expected beats per line (0 = check disabled)
- cfg_lines_per_frame  in  LINE_CNT_WIDTH  expected lines per frame (0 = check disabled)
- err_clr  in  1  clears all sticky errors
- frame_done  out  1  one-cycle pulse on the EOF beat
- frame_count  out  FRAME_CNT_WIDTH  completed frames, wraps
- line_count  out  LINE_CNT_WIDTH  lines received in the current or last frame
- stall_count  out  FRAME_CNT_WIDTH  cycles with tvalid=1 and tready=0, saturating
- err_flags  out  5  sticky: [0] unexpected SOF, [1] missing SOF, [2] line length, [3] line count, [4] tlast/EOL mismatch
- in_frame  out  1  high from the SOF beat up to (excluding) the cycle after EOF

Behaviour:
- Beat = tvalid & tready. Only beats advance state. tdata/tuser/tlast are ignored on non-beat cycles.
- Reset values: every output is 0; state = IDLE; all internal counters are 0.
- FSM states: IDLE, LINE, GAP.
  - IDLE, beat with SOF -> LINE. line_count:=0, beat counter:=1.
  - IDLE, beat without SOF -> stay IDLE and set err[1].
  - LINE, beat without tlast -> increment the beat counter.
  - LINE, beat with tlast -> line ends: compare beats, increment line_count. Go to GAP, or to IDLE if EOF.
  - GAP, beat with SOL -> LINE, beat counter:=1.
  - GAP, beat without SOL -> still enter LINE and set err[4].
- Checks:
  - Line length: at tlast, if cfg_beats_per_line≠0 and the beat counter (including this beat) ≠ cfg -> set err[2].
  - Line count: at EOF, if cfg_lines_per_frame≠0 and line_count (after increment) ≠ cfg -> set err[3].
  - tlast/EOL mismatch: (tlast XOR EOL) on any beat sets err[4].
  - EOF without tlast also sets err[4]; treat the beat as end of frame.
  - SOF in LINE or GAP sets err[0]. The current frame is abandoned without counting; restart as a new frame (counters reloaded as from IDLE).
- Single-beat frame (SOF, SOL, EOL, EOF and tlast all on one beat): legal; frame_done fires and line_count=1.
- frame_done and the frame_count increment are registered: both appear one cycle after the EOF beat. frame_count wraps modulo 2^FRAME_CNT_WIDTH.
- Counter overflow:
  - Beat counter saturates at all-ones and err[2] is forced at tlast.
  - line_count saturates.
- err_clr and a new error in the same cycle: the error wins (the bit stays set).
- Config values are sampled at each check event. Changing them mid-frame affects only later checks.
- aclk_reset mid-frame: immediate return to reset values. A stream already mid-frame after reset reports err[1] until the next SOF.
- Latency: all outputs are registered, one cycle after the causing beat.

Optional Feature:
- Macro: AXIS_FRAME_CHECKSUM_EN.
- When defined:
  - Extra output frame_checksum, T_DATA_WIDTH wide, reset 0.
  - It holds the XOR of tdata over all beats of the last completed frame and is updated in the same cycle as frame_done.
  - The internal accumulator is cleared on SOF.
- When undefined: the port and the accumulator are absent, and all other behaviour is identical.

Test Plan:
- Nominal frames:
  - Stimulus: cfg 4 beats x 3 lines; stream 2 correct frames with continuous tready.
  - Required: frame_count=2, line_count=3, err_flags=0, two frame_done pulses, each 1 cycle after its EOF beat.
- Short line:
  - Stimulus: cfg 4 beats; line 2 has tlast on beat 3.
  - Required: err_flags=5'b00100, remains set until err_clr, cleared the cycle after err_clr.
- Backpressure:
  - Stimulus: hold tready=0 for 7 cycles while tvalid=1 mid-line.
  - Required: stall_count=7; beat counts are unaffected, no errors.
- Protocol errors:
  - Stimulus: SOF mid-frame.
  - Required: err[0]=1, frame_count not incremented for the aborted frame; the new frame completes normally (+1).
  - Stimulus: data beat in IDLE without SOF.
  - Required: err[1]=1.
- Reset and clear:
  - Stimulus: assert aclk_reset during line 2.
  - Required: all outputs 0 next cycle; the following full frame counts as frame_count=1.
  - Stimulus: err_clr in the same cycle as a new line-length error.
  - Required: err[2] stays 1.
- Checksum (AXIS_FRAME_CHECKSUM_EN defined):
  - Stimulus: frame of beats 0x1, 0x2, 0x4, 0x8.
  - Required: frame_checksum=0xF when frame_done is asserted.
